// File: rtl/packet_pkg.sv
// Shared port-mask types, FSM states and helpers for the switch output arbiter.
package packet_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [3:0] port_mask_t;
  typedef logic [1:0] port_idx_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_GRANTED
  } arb_state_t;

  // An input never targets its own output; drop the self bit before latching.
  function automatic port_mask_t sanitize_mask(input port_mask_t m, input port_idx_t self);
    port_mask_t r;
    r       = m;
    r[self] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Greedy round-robin scan: grants every waiting input whose whole mask is free,
// claiming outputs as it goes so granted masks in one cycle are disjoint.
module arb_rr_picker
  import packet_pkg::*;
(
  input  logic       [NUM_PORTS-1:0] wait_vec,
  input  port_mask_t [NUM_PORTS-1:0] mask,
  input  port_mask_t                 busy,
  input  port_mask_t [NUM_PORTS-1:0] reserved,
  input  port_idx_t                  rr_ptr,
  output logic       [NUM_PORTS-1:0] grant_now
);

  port_mask_t claimed;
  port_idx_t  idx;

  always_comb begin
    grant_now = '0;
    claimed   = busy;
    idx       = rr_ptr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr_ptr + port_idx_t'(k);
      if (wait_vec[idx] && ((mask[idx] & (claimed | reserved[idx])) == '0)) begin
        grant_now[idx] = 1'b1;
        claimed        = claimed | mask[idx];
      end
    end
  end

endmodule

// File: rtl/switch_output_arbiter.sv
// All-or-nothing output allocator for the 4-port switch with round-robin, starvation
// reservation and hold timeout. Define ARB_STATS_EN to add stats_clr/grant_cnt.
module switch_output_arbiter
  import packet_pkg::*;
#(
  parameter int STARVE_LIMIT = 16,
  parameter int MAX_HOLD     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic       [NUM_PORTS-1:0] req_valid,
  input  port_mask_t [NUM_PORTS-1:0] req_mask,
  input  logic       [NUM_PORTS-1:0] req_done,
  output logic       [NUM_PORTS-1:0] grant,
  output port_mask_t                 out_busy,
  output port_idx_t  [NUM_PORTS-1:0] out_owner,
  output logic       [NUM_PORTS-1:0] starve,
  output logic       [NUM_PORTS-1:0] timeout
`ifdef ARB_STATS_EN
  ,
  input  logic                       stats_clr,
  output logic [NUM_PORTS-1:0][15:0] grant_cnt
`endif
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t                 state_q [NUM_PORTS];
  arb_state_t                 state_d [NUM_PORTS];
  port_mask_t [NUM_PORTS-1:0] mask_q, mask_d;
  logic       [WAIT_W-1:0]    wait_q  [NUM_PORTS];
  logic       [WAIT_W-1:0]    wait_d  [NUM_PORTS];
  logic       [HOLD_W-1:0]    hold_q  [NUM_PORTS];
  logic       [HOLD_W-1:0]    hold_d  [NUM_PORTS];
  logic       [NUM_PORTS-1:0] timeout_q, timeout_d;
  port_idx_t                  rr_q, rr_d;

  port_mask_t [NUM_PORTS-1:0] eff_mask;
  port_mask_t [NUM_PORTS-1:0] blocked;
  logic       [NUM_PORTS-1:0] waiting;
  logic       [NUM_PORTS-1:0] grant_now;
  logic                       reserve_any;
  port_idx_t                  reserve_idx;
  port_mask_t                 reserve_mask;
  port_idx_t                  scan_idx;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      eff_mask[i] = sanitize_mask(req_mask[i], port_idx_t'(i));
      waiting[i]  = (state_q[i] == ARB_WAIT);
      grant[i]    = (state_q[i] == ARB_GRANTED);
      starve[i]   = (wait_q[i] == WAIT_W'(STARVE_LIMIT));
    end
  end

  // Ownership is derived from registered state so an async reset drops it at once.
  always_comb begin
    out_busy  = '0;
    out_owner = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (grant[i] && mask_q[i][o]) begin
          out_busy[o]  = 1'b1;
          out_owner[o] = port_idx_t'(i);
        end
      end
    end
  end

  // Lowest-index starved input fences its outputs off from everyone else.
  always_comb begin
    reserve_any = 1'b0;
    reserve_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (starve[i]) begin
        reserve_any = 1'b1;
        reserve_idx = port_idx_t'(i);
      end
    end
    reserve_mask = reserve_any ? mask_q[reserve_idx] : '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      blocked[i] = (reserve_any && (reserve_idx != port_idx_t'(i))) ? reserve_mask : '0;
    end
  end

  arb_rr_picker u_picker (
    .wait_vec  (waiting),
    .mask      (mask_q),
    .busy      (out_busy),
    .reserved  (blocked),
    .rr_ptr    (rr_q),
    .grant_now (grant_now)
  );

  always_comb begin
    rr_d     = rr_q;
    scan_idx = rr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = rr_q + port_idx_t'(k);
      if (grant_now[scan_idx]) rr_d = scan_idx + port_idx_t'(1);
    end
  end

  always_comb begin
    mask_d    = mask_q;
    timeout_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      state_d[i] = state_q[i];
      wait_d[i]  = wait_q[i];
      hold_d[i]  = hold_q[i];
      unique case (state_q[i])
        ARB_IDLE: begin
          if (req_valid[i] && (eff_mask[i] != '0)) begin
            state_d[i] = ARB_WAIT;
            mask_d[i]  = eff_mask[i];
            wait_d[i]  = '0;
          end
        end
        ARB_WAIT: begin
          if (grant_now[i]) begin
            state_d[i] = ARB_GRANTED;
            wait_d[i]  = '0;
            hold_d[i]  = '0;
          end else if (wait_q[i] != WAIT_W'(STARVE_LIMIT)) begin
            wait_d[i] = wait_q[i] + WAIT_W'(1);
          end
        end
        ARB_GRANTED: begin
          // A done on the final hold cycle is a normal release, not a timeout.
          if (req_done[i]) begin
            state_d[i] = ARB_IDLE;
            mask_d[i]  = '0;
            hold_d[i]  = '0;
          end else if (hold_q[i] == HOLD_W'(MAX_HOLD - 1)) begin
            state_d[i]   = ARB_IDLE;
            mask_d[i]    = '0;
            hold_d[i]    = '0;
            timeout_d[i] = 1'b1;
          end else begin
            hold_d[i] = hold_q[i] + HOLD_W'(1);
          end
        end
        default: begin
          state_d[i] = ARB_IDLE;
          mask_d[i]  = '0;
          wait_d[i]  = '0;
          hold_d[i]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= ARB_IDLE;
        wait_q[i]  <= '0;
        hold_q[i]  <= '0;
      end
      mask_q    <= '0;
      timeout_q <= '0;
      rr_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= state_d[i];
        wait_q[i]  <= wait_d[i];
        hold_q[i]  <= hold_d[i];
      end
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
      rr_q      <= rr_d;
    end
  end

  assign timeout = timeout_q;

`ifdef ARB_STATS_EN
  logic [NUM_PORTS-1:0][15:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (stats_clr) begin
      grant_cnt_d = '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_now[i] && (grant_cnt_q[i] != 16'hFFFF)) grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_cnt_q <= '0;
    else        grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Scenario bench for switch_output_arbiter: expected snapshots are queued as stimulus
// is driven and compared against {grant, out_busy, out_owner, starve, timeout}.
module tb_switch_output_arbiter;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0][3:0] req_mask;
  logic [3:0]      req_done;
  logic [3:0]      grant;
  logic [3:0]      out_busy;
  logic [3:0][1:0] out_owner;
  logic [3:0]      starve;
  logic [3:0]      timeout;
`ifdef ARB_STATS_EN
  logic             stats_clr;
  logic [3:0][15:0] grant_cnt;
`endif

  typedef struct {
    string       tag;
    logic [23:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  switch_output_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_mask  (req_mask),
    .req_done  (req_done),
    .grant     (grant),
    .out_busy  (out_busy),
    .out_owner (out_owner),
    .starve    (starve),
    .timeout   (timeout)
`ifdef ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] snap(input logic [3:0] g, input logic [3:0] b,
                                       input logic [7:0] o, input logic [3:0] s,
                                       input logic [3:0] t);
    return {g, b, o, s, t};
  endfunction

  function automatic logic [23:0] actual();
    return {grant, out_busy, out_owner, starve, timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_done  = '0;
    req_mask  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_q.push_back('{tag: "reset_state", val: 24'h0});
    #1;
    e = exp_q.pop_front();
    vectors++;
    if (actual() !== e.val) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", e.tag, actual(), e.val);
    end
  endtask

  task automatic test_multicast_clash();
    exp_t        e;
    logic [23:0] x;
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      clear_inputs();
      if (n == 1) begin
        req_valid   = 4'b0011;
        req_mask[0] = 4'b1100;
        req_mask[1] = 4'b1100;
      end
      if (n == 4) req_done[0] = 1'b1;
      if (n == 6) req_done[1] = 1'b1;
      case (n)
        2, 3:    x = snap(4'b0001, 4'b1100, 8'h00, 4'h0, 4'h0);
        5:       x = snap(4'b0010, 4'b1100, 8'h50, 4'h0, 4'h0);
        default: x = 24'h0;
      endcase
      exp_q.push_back('{tag: $sformatf("clash_e%0d", n), val: x});
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (actual() !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", e.tag, actual(), e.val);
      end
    end
  endtask

  task automatic test_broadcast_vs_unicast();
    exp_t        e;
    logic [23:0] x;
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      clear_inputs();
      if (n == 1) begin
        req_valid   = 4'b1100;
        req_mask[2] = 4'b1111;
        req_mask[3] = 4'b0001;
      end
      if (n == 3) req_done[2] = 1'b1;
      if (n == 5) req_done[3] = 1'b1;
      case (n)
        2:       x = snap(4'b0100, 4'b1011, 8'h8A, 4'h0, 4'h0);
        4:       x = snap(4'b1000, 4'b0001, 8'h03, 4'h0, 4'h0);
        default: x = 24'h0;
      endcase
      exp_q.push_back('{tag: $sformatf("bcast_e%0d", n), val: x});
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (actual() !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", e.tag, actual(), e.val);
      end
    end
  endtask

  // Also covers: self-only mask ignored, req_valid ignored outside IDLE,
  // and done+valid on one edge releasing without starting a new request.
  task automatic test_disjoint_parallel();
    exp_t        e;
    logic [23:0] x;
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      clear_inputs();
      if (n == 1) begin
        req_valid   = 4'b0111;
        req_mask[0] = 4'b0010;
        req_mask[1] = 4'b0010;
        req_mask[2] = 4'b1000;
      end
      if (n == 2) begin
        req_valid[0] = 1'b1;
        req_mask[0]  = 4'b0100;
      end
      if (n == 3) begin
        req_done     = 4'b0101;
        req_valid[0] = 1'b1;
        req_mask[0]  = 4'b0100;
      end
      x = (n == 2) ? snap(4'b0101, 4'b1010, 8'h80, 4'h0, 4'h0) : 24'h0;
      exp_q.push_back('{tag: $sformatf("disjoint_e%0d", n), val: x});
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (actual() !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", e.tag, actual(), e.val);
      end
    end
  endtask

  // P0 (output 1) and P1 (output 3) alternate so P2's broadcast never finds all free
  // until its starve reservation fences them off.
  task automatic test_starvation();
    exp_t        e;
    logic [3:0]  g;
    logic [3:0]  b;
    logic [7:0]  o;
    logic [3:0]  s;
    do_reset();
    for (int n = 1; n <= 22; n++) begin
      clear_inputs();
      if (n == 1) begin
        req_valid[2] = 1'b1;
        req_mask[2]  = 4'b1111;
      end
      if (n <= 17 && (n % 4) == 1) begin
        req_valid[0] = 1'b1;
        req_mask[0]  = 4'b0010;
      end
      if (n >= 4 && n <= 16 && (n % 4) == 0) req_done[0] = 1'b1;
      if (n <= 19 && (n % 4) == 3) begin
        req_valid[1] = 1'b1;
        req_mask[1]  = 4'b1000;
      end
      if (n >= 6 && n <= 18 && (n % 4) == 2) req_done[1] = 1'b1;
      if (n == 20) req_done[2] = 1'b1;
      if (n == 22) req_done[1:0] = 2'b11;

      g = '0;
      if (n >= 2 && n <= 15 && ((n % 4) == 2 || (n % 4) == 3)) g[0] = 1'b1;
      if (n >= 4 && n <= 17 && ((n % 4) == 0 || (n % 4) == 1)) g[1] = 1'b1;
      if (n == 19) g[2] = 1'b1;
      if (n == 21) g[1:0] = 2'b11;
      b = '0;
      o = '0;
      if (g[0]) b = b | 4'b0010;
      if (g[1]) begin
        b      = b | 4'b1000;
        o[7:6] = 2'd1;
      end
      if (g[2]) begin
        b = b | 4'b1011;
        o = 8'h8A;
      end
      s = (n == 17 || n == 18) ? 4'b0100 : 4'b0000;
      exp_q.push_back('{tag: $sformatf("starve_e%0d", n), val: snap(g, b, o, s, 4'h0)});
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (actual() !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", e.tag, actual(), e.val);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t        e;
    logic [23:0] x;
    do_reset();
    for (int n = 1; n <= 67; n++) begin
      clear_inputs();
      if (n == 1) begin
        req_valid[1] = 1'b1;
        req_mask[1]  = 4'b0100;
      end
      if (n >= 2 && n <= 65) x = snap(4'b0010, 4'b0100, 8'h10, 4'h0, 4'h0);
      else if (n == 66)      x = snap(4'h0, 4'h0, 8'h00, 4'h0, 4'b0010);
      else                   x = 24'h0;
      exp_q.push_back('{tag: $sformatf("timeout_e%0d", n), val: x});
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (actual() !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", e.tag, actual(), e.val);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    exp_t        e;
    logic [23:0] x;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      if (k == 0) begin
        req_valid[0] = 1'b1;
        req_mask[0]  = 4'b1110;
      end
      x = (k == 1) ? snap(4'b0001, 4'b1110, 8'h00, 4'h0, 4'h0) : 24'h0;
      exp_q.push_back('{tag: $sformatf("rstmid_s%0d", k), val: x});
      if (k == 2) begin
        #2;
        rst_n = 1'b0;
        #1;
      end else if (k == 3) begin
        tick();
        rst_n = 1'b1;
        tick();
      end else begin
        tick();
      end
      e = exp_q.pop_front();
      vectors++;
      if (actual() !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", e.tag, actual(), e.val);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clear_inputs();
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_multicast_clash();
    test_broadcast_vs_unicast();
    test_disjoint_parallel();
    test_starvation();
    test_timeout();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
